icache_line_buffer_if: RTL and testbench
========================================

// Module: icache_line_buffer_if
// PURPOSE
//  Parametrised successor of the fetch<->ICache interface. Sits between fetch and ICache.
//  Keeps a one-line buffer: sequential fetches that hit the last returned line are served
//  without an ICache access. Supports up to MAX_OUTST in-flight misses via a pending-PC FIFO.
//  Flush and kill discard in-flight responses. Drives real PMU hit/miss pulses.
// PARAMETERS
//  VADDR_W    39   virtual fetch address width
//  LINE_W     128  ICache line width in bits; power of 2, >= 2*INSTR_W
//  INSTR_W    32   instruction word width
//  MAX_OUTST  2    maximum in-flight ICache requests; power of 2, >= 1
// PORTS
//  Clocking: one clock, clk_i. Reset is synchronous, active-high, port rst_i.
//  clk_i            in   1          clock
//  rst_i            in   1          synchronous active-high reset
//  fetch_valid_i    in   1          fetch request valid
//  fetch_vaddr_i    in   VADDR_W    fetch PC
//  fetch_kill_i     in   1          kill in-flight fetches (branch redirect)
//  fetch_flush_i    in   1          invalidate line buffer (fence.i / satp change)
//  fetch_ready_o    out  1          request accepted this cycle when valid & ready
//  ic_req_ready_i   in   1          ICache can accept a request
//  ic_req_valid_o   out  1          ICache request
//  ic_req_vpn_o     out  VADDR_W-12 vaddr[VADDR_W-1:12]
//  ic_req_idx_o     out  12         vaddr[11:0]
//  ic_req_kill_o    out  1          = fetch_kill_i
//  ic_invalidate_o  out  1          = fetch_flush_i
//  ic_resp_valid_i  in   1          ICache response, in order
//  ic_resp_line_i   in   LINE_W     response line
//  tlb_xcpt_if_i    in   1          page fault for the head request; counts as a response
//  resp_valid_o     out  1          instruction to fetch
//  resp_data_o      out  INSTR_W    instruction word
//  resp_pf_o        out  1          instruction page fault
//  pmu_hit_o        out  1          one-cycle pulse per buffer hit
//  pmu_miss_o       out  1          one-cycle pulse per ICache request issued
// BEHAVIOUR
//  Definitions
//  - OFF_W = log2(LINE_W/8). tag = vaddr[VADDR_W-1:OFF_W]. word = vaddr[OFF_W-1:2].
//  Reset
//  - All outputs 0. Line buffer invalid. FIFO empty. drop_cnt = 0.
//  Hit
//  - Condition: fetch_valid_i & buf_valid & tag==buf_tag & FIFO empty & ~kill & ~flush.
//  - Accepted even when ic_req_ready_i = 0.
//  - Registered response 1 cycle later: resp_valid_o=1, data=buf_line[word], pf=0.
//  - pmu_hit_o pulses. No ICache request.
//  Miss
//  - Condition: valid & ~hit & ~kill & ~flush & ic_req_ready_i & ~fifo_full.
//  - ic_req_valid_o=1, vaddr pushed to FIFO, pmu_miss_o pulses.
//  fetch_ready_o
//  - = hit | (ic_req_ready_i & ~fifo_full & ~kill & ~flush).
//  Response (ic_resp_valid_i | tlb_xcpt_if_i, FIFO non-empty)
//  - Pop head. If drop_cnt > 0: decrement, no output, no fill.
//  - Else resp_valid_o=1 combinationally. tlb_xcpt has priority: data=0, pf=1, no fill.
//  - Otherwise data=line[head.word] and buffer <= {head.tag, line}, valid.
//  - A response with an empty FIFO is ignored (assertion).
//  Kill/flush
//  - kill|flush: drop_cnt <= FIFO occupancy after this cycle's pop.
//  - flush also clears buf_valid.
//  - kill also cancels a pending registered hit response.
//  - Same-cycle new request is not accepted.
//  Collision
//  - Hit responses need an empty FIFO, and ICache latency is >= 1, so a registered hit and
//    an ICache response never coincide (assertion).
//  Full/simultaneous
//  - Full FIFO with a same-cycle pop still blocks the push: ready uses registered full.
//  - drop_cnt never exceeds MAX_OUTST.
//  Reset mid-operation
//  - Clears FIFO and buffer. Late ICache responses after reset are ignored (empty FIFO).
// STRUCTURE
//  - drac_pkg: icache_lb_entry_t {tag, word}; function line_off_w(LINE_W).
//  - Sub-module pending_pc_fifo (DEPTH=MAX_OUTST, entry type).
//    Push/pop, full/empty, count, sync active-high reset.
//  - Top: hit/miss logic, line buffer regs, drop counter, response mux.
// TESTING
//  - Reset, then miss 0x1000, resp line {D3,D2,D1,D0} -> resp_data=D0, pmu_miss=1.
//  - Fetch 0x1004, 0x1008 -> no ic_req, data D1 then D2 one cycle after each; pmu_hit x2.
//  - Misses 0x2000, 0x3000 back-to-back (MAX_OUTST=2) -> third request stalled until pop.
//    In-order data.
//  - Two in flight, kill -> both responses swallowed, resp_valid_o=0.
//    Next miss 0x4000 delivered.
//  - Flush after fill of 0x1000, refetch 0x1004 -> ICache request issued (miss, not hit).
//  - tlb_xcpt_if_i on head 0x5000 -> resp_pf=1, data=0.
//    Buffer unchanged: 0x1000 still hits if FIFO empty.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared types and helpers for the fetch <-> ICache line-buffer interface.
package drac_pkg;

  localparam int unsigned DEF_VADDR_W = 39;
  localparam int unsigned DEF_LINE_W  = 128;

  function automatic int unsigned line_off_w(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  localparam int unsigned DEF_OFF_W = line_off_w(DEF_LINE_W);

  typedef struct packed {
    logic [DEF_VADDR_W-DEF_OFF_W-1:0] tag;
    logic [DEF_OFF_W-3:0]             word;
  } icache_lb_entry_t;

endpackage

// File: rtl/pending_pc_fifo.sv
// Generic FIFO of outstanding fetch entries; head readable combinationally, push/pop same cycle.
// Full/empty/count come from the registered count, so a same-cycle pop never frees a slot early.
module pending_pc_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type T = logic,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  T                 push_dat_i,
  input  logic             pop_i,
  output T                 head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o     = (r_cnt == CNT_W'(DEPTH));
  assign empty_o    = (r_cnt == '0);
  assign cnt_o      = r_cnt;
  assign head_dat_o = r_mem[r_rd_ptr];
  assign w_push     = push_i & ~full_o;
  assign w_pop      = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/icache_line_buffer_if.sv
// Fetch<->ICache shim with a one-line buffer: hits answer 1 cycle later, misses answer when the ICache does.
// Misses stall on ICache not-ready or a full pending FIFO; kill/flush drop in-flight responses.
module icache_line_buffer_if
  import drac_pkg::*;
#(
  parameter int unsigned VADDR_W   = 39,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fetch_valid_i,
  input  logic [VADDR_W-1:0]  fetch_vaddr_i,
  input  logic                fetch_kill_i,
  input  logic                fetch_flush_i,
  output logic                fetch_ready_o,
  input  logic                ic_req_ready_i,
  output logic                ic_req_valid_o,
  output logic [VADDR_W-13:0] ic_req_vpn_o,
  output logic [11:0]         ic_req_idx_o,
  output logic                ic_req_kill_o,
  output logic                ic_invalidate_o,
  input  logic                ic_resp_valid_i,
  input  logic [LINE_W-1:0]   ic_resp_line_i,
  input  logic                tlb_xcpt_if_i,
  output logic                resp_valid_o,
  output logic [INSTR_W-1:0]  resp_data_o,
  output logic                resp_pf_o,
  output logic                pmu_hit_o,
  output logic                pmu_miss_o
);

  localparam int unsigned OFF_W  = line_off_w(LINE_W);
  localparam int unsigned TAG_W  = VADDR_W - OFF_W;
  localparam int unsigned WORD_W = OFF_W - 2;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] word;
  } entry_t;

  logic               r_buf_vld;
  logic [TAG_W-1:0]   r_buf_tag;
  logic [LINE_W-1:0]  r_buf_line;
  logic               r_hit_vld;
  logic [INSTR_W-1:0] r_hit_dat;
  logic [CNT_W-1:0]   r_drop_cnt;

  entry_t             w_push_ent;
  entry_t             w_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_fifo_cnt;
  logic               w_kf;
  logic               w_hit;
  logic               w_req_ok;
  logic               w_miss;
  logic               w_rsp_evt;
  logic               w_drop;
  logic               w_deliver;
  logic               w_hit_out;
  logic [INSTR_W-1:0] w_resp_word;
  logic               w_unused;

  assign w_kf       = fetch_kill_i | fetch_flush_i;
  assign w_push_ent = '{tag: fetch_vaddr_i[VADDR_W-1:OFF_W], word: fetch_vaddr_i[OFF_W-1:2]};
  assign w_unused   = ^fetch_vaddr_i[1:0];

  // A hit is only legal with nothing pending, so buffer data can never overtake an older miss.
  assign w_hit    = ~rst_i & fetch_valid_i & r_buf_vld & (w_push_ent.tag == r_buf_tag)
                  & w_fifo_empty & ~w_kf;
  assign w_req_ok = ~rst_i & ic_req_ready_i & ~w_fifo_full & ~w_kf;
  assign w_miss   = fetch_valid_i & ~w_hit & w_req_ok;

  assign fetch_ready_o   = w_hit | w_req_ok;
  assign ic_req_valid_o  = w_miss;
  assign ic_req_vpn_o    = w_miss ? fetch_vaddr_i[VADDR_W-1:12] : '0;
  assign ic_req_idx_o    = w_miss ? fetch_vaddr_i[11:0] : '0;
  assign ic_req_kill_o   = fetch_kill_i;
  assign ic_invalidate_o = fetch_flush_i;
  assign pmu_hit_o       = w_hit;
  assign pmu_miss_o      = w_miss;

  assign w_rsp_evt   = ~rst_i & (ic_resp_valid_i | tlb_xcpt_if_i) & ~w_fifo_empty;
  assign w_drop      = w_rsp_evt & (r_drop_cnt != '0);
  assign w_deliver   = w_rsp_evt & ~w_drop;
  assign w_hit_out   = ~rst_i & r_hit_vld & ~fetch_kill_i;
  assign w_resp_word = ic_resp_line_i[w_head.word*INSTR_W +: INSTR_W];

  pending_pc_fifo #(
    .DEPTH (MAX_OUTST),
    .T     (entry_t)
  ) u_pending_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (w_miss),
    .push_dat_i (w_push_ent),
    .pop_i      (w_rsp_evt),
    .head_dat_o (w_head),
    .full_o     (w_fifo_full),
    .empty_o    (w_fifo_empty),
    .cnt_o      (w_fifo_cnt)
  );

  always_comb begin
    resp_valid_o = 1'b0;
    resp_data_o  = '0;
    resp_pf_o    = 1'b0;
    if (w_deliver) begin
      resp_valid_o = 1'b1;
      if (tlb_xcpt_if_i) resp_pf_o   = 1'b1;
      else               resp_data_o = w_resp_word;
    end else if (w_hit_out) begin
      resp_valid_o = 1'b1;
      resp_data_o  = r_hit_dat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_buf_vld  <= 1'b0;
      r_buf_tag  <= '0;
      r_buf_line <= '0;
      r_hit_vld  <= 1'b0;
      r_hit_dat  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_hit_vld <= w_hit;
      r_hit_dat <= r_buf_line[w_push_ent.word*INSTR_W +: INSTR_W];
      if (fetch_flush_i) begin
        r_buf_vld <= 1'b0;
      end else if (w_deliver & ~tlb_xcpt_if_i) begin
        r_buf_vld  <= 1'b1;
        r_buf_tag  <= w_head.tag;
        r_buf_line <= ic_resp_line_i;
      end
      // No push can happen under kill/flush, so post-pop occupancy is exactly what is still in flight.
      if (w_kf)        r_drop_cnt <= w_fifo_cnt - CNT_W'(w_rsp_evt);
      else if (w_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
    end
  end

  a_resp_needs_pending: assert property (@(posedge clk_i) disable iff (rst_i)
    (ic_resp_valid_i | tlb_xcpt_if_i) |-> ~w_fifo_empty);
  a_no_hit_resp_collision: assert property (@(posedge clk_i) disable iff (rst_i)
    r_hit_vld |-> ~w_rsp_evt);
  a_drop_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    r_drop_cnt <= CNT_W'(MAX_OUTST));

endmodule

// File: tb/tb_icache_line_buffer_if.sv
// Directed bench: stimulus pushes expected responses/requests, a negedge monitor pops and compares.
module tb_icache_line_buffer_if;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          fetch_valid_i;
  logic [38:0]   fetch_vaddr_i;
  logic          fetch_kill_i;
  logic          fetch_flush_i;
  logic          fetch_ready_o;
  logic          ic_req_ready_i;
  logic          ic_req_valid_o;
  logic [26:0]   ic_req_vpn_o;
  logic [11:0]   ic_req_idx_o;
  logic          ic_req_kill_o;
  logic          ic_invalidate_o;
  logic          ic_resp_valid_i;
  logic [127:0]  ic_resp_line_i;
  logic          tlb_xcpt_if_i;
  logic          resp_valid_o;
  logic [31:0]   resp_data_o;
  logic          resp_pf_o;
  logic          pmu_hit_o;
  logic          pmu_miss_o;

  always #5 clk_i = ~clk_i;

  icache_line_buffer_if #(
    .VADDR_W(39), .LINE_W(128), .INSTR_W(32), .MAX_OUTST(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_valid_i(fetch_valid_i), .fetch_vaddr_i(fetch_vaddr_i),
    .fetch_kill_i(fetch_kill_i), .fetch_flush_i(fetch_flush_i),
    .fetch_ready_o(fetch_ready_o),
    .ic_req_ready_i(ic_req_ready_i), .ic_req_valid_o(ic_req_valid_o),
    .ic_req_vpn_o(ic_req_vpn_o), .ic_req_idx_o(ic_req_idx_o),
    .ic_req_kill_o(ic_req_kill_o), .ic_invalidate_o(ic_invalidate_o),
    .ic_resp_valid_i(ic_resp_valid_i), .ic_resp_line_i(ic_resp_line_i),
    .tlb_xcpt_if_i(tlb_xcpt_if_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_pf_o(resp_pf_o),
    .pmu_hit_o(pmu_hit_o), .pmu_miss_o(pmu_miss_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cnt_hit = 0;
  int cnt_miss = 0;
  logic [31:0] exp_dat_q[$];
  logic        exp_pf_q[$];
  logic [38:0] exp_req_q[$];
  logic [31:0] m_dat;
  logic        m_pf;
  logic [38:0] m_req;

  logic [127:0] L1, L2, L3, L4, LX;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_resp(input logic [31:0] d, input logic pf);
    exp_dat_q.push_back(d);
    exp_pf_q.push_back(pf);
  endtask

  // Monitor: every presented response / ICache request is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (pmu_hit_o)  cnt_hit++;
      if (pmu_miss_o) cnt_miss++;
      if (resp_valid_o) begin
        if (exp_dat_q.size() == 0) chk("unexpected_resp", resp_valid_o, 0);
        else begin
          m_dat = exp_dat_q.pop_front();
          m_pf  = exp_pf_q.pop_front();
          chk("resp_data", resp_data_o, m_dat);
          chk("resp_pf", resp_pf_o, m_pf);
        end
      end
      if (ic_req_valid_o && ic_req_ready_i) begin
        if (exp_req_q.size() == 0) chk("unexpected_ic_req", ic_req_valid_o, 0);
        else begin
          m_req = exp_req_q.pop_front();
          chk("ic_req_addr", {ic_req_vpn_o, ic_req_idx_o}, m_req);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [38:0] a);
    int n = 0;
    fetch_valid_i = 1'b1;
    fetch_vaddr_i = a;
    @(negedge clk_i);
    while (!fetch_ready_o && n < 20) begin
      tick();
      @(negedge clk_i);
      n++;
    end
    if (!fetch_ready_o) chk("fetch_accept_timeout", fetch_ready_o, 1);
    tick();
    fetch_valid_i = 1'b0;
  endtask

  task automatic icresp(input logic [127:0] ln, input logic xcpt);
    ic_resp_valid_i = ~xcpt;
    tlb_xcpt_if_i   = xcpt;
    ic_resp_line_i  = ln;
    tick();
    ic_resp_valid_i = 1'b0;
    tlb_xcpt_if_i   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    L1 = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    L2 = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
    L3 = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    L4 = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
    LX = {4{32'hBAD0_BAD0}};
    rst_i = 1'b1; fetch_valid_i = 1'b1; fetch_vaddr_i = 39'h1000;
    fetch_kill_i = 1'b0; fetch_flush_i = 1'b0; ic_req_ready_i = 1'b1;
    ic_resp_valid_i = 1'b0; ic_resp_line_i = '0; tlb_xcpt_if_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_fetch_ready", fetch_ready_o, 0);
    chk("rst_ic_req_valid", ic_req_valid_o, 0);
    chk("rst_pmu_miss", pmu_miss_o, 0);
    chk("rst_pmu_hit", pmu_hit_o, 0);
    tick();
    rst_i = 1'b0; fetch_valid_i = 1'b0;
    @(negedge clk_i);
    chk("idle_fetch_ready", fetch_ready_o, 1);
    chk("idle_resp_valid", resp_valid_o, 0);
    tick();

    // First miss and fill
    exp_req_q.push_back(39'h1000);
    fetch(39'h1000);
    expect_resp(32'hD0D0_0000, 1'b0);
    icresp(L1, 1'b0);
    tick();
    chk("miss_count_first", cnt_miss, 1);

    // Sequential hits; second one with the ICache not ready
    expect_resp(32'hD1D1_0001, 1'b0);
    fetch(39'h1004);
    ic_req_ready_i = 1'b0;
    expect_resp(32'hD2D2_0002, 1'b0);
    fetch(39'h1008);
    ic_req_ready_i = 1'b1;
    tick(); tick();
    chk("hit_count_two", cnt_hit, 2);

    // Two outstanding misses, third stalls until a pop has retired
    exp_req_q.push_back(39'h2000);
    exp_req_q.push_back(39'h3000);
    exp_req_q.push_back(39'h1004);
    fetch(39'h2000);
    fetch(39'h3000);
    fetch_valid_i = 1'b1; fetch_vaddr_i = 39'h1004;
    @(negedge clk_i);
    chk("full_stall", fetch_ready_o, 0);
    tick();
    expect_resp(32'h2222_0000, 1'b0);
    ic_resp_valid_i = 1'b1; ic_resp_line_i = L2;
    @(negedge clk_i);
    chk("full_same_cycle_pop_stall", fetch_ready_o, 0);
    tick();
    ic_resp_valid_i = 1'b0;
    fetch(39'h1004);
    expect_resp(32'h3333_0000, 1'b0);
    icresp(L3, 1'b0);
    expect_resp(32'hD1D1_0001, 1'b0);
    icresp(L1, 1'b0);
    tick();

    // Kill with two in flight: both responses swallowed
    exp_req_q.push_back(39'h6000);
    exp_req_q.push_back(39'h7000);
    fetch(39'h6000);
    fetch(39'h7000);
    fetch_kill_i = 1'b1;
    @(negedge clk_i);
    chk("kill_passthru", ic_req_kill_o, 1);
    chk("kill_blocks_ready", fetch_ready_o, 0);
    tick();
    fetch_kill_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ic_resp_valid_i = 1'b1; ic_resp_line_i = LX;
      @(negedge clk_i);
      chk("killed_resp_swallowed", resp_valid_o, 0);
      tick();
    end
    ic_resp_valid_i = 1'b0;
    exp_req_q.push_back(39'h4000);
    fetch(39'h4000);
    expect_resp(32'h4444_0000, 1'b0);
    icresp(L4, 1'b0);
    tick();

    // Flush after a fill of 0x1000 forces the refetch to miss
    exp_req_q.push_back(39'h1000);
    fetch(39'h1000);
    expect_resp(32'hD0D0_0000, 1'b0);
    icresp(L1, 1'b0);
    fetch_flush_i = 1'b1; fetch_valid_i = 1'b1; fetch_vaddr_i = 39'h1004;
    @(negedge clk_i);
    chk("flush_invalidate", ic_invalidate_o, 1);
    chk("flush_blocks_ready", fetch_ready_o, 0);
    tick();
    fetch_flush_i = 1'b0;
    exp_req_q.push_back(39'h1004);
    fetch(39'h1004);
    expect_resp(32'hD1D1_0001, 1'b0);
    icresp(L1, 1'b0);
    tick();

    // Page fault on head: pf response, buffer untouched
    exp_req_q.push_back(39'h5000);
    fetch(39'h5000);
    expect_resp(32'h0, 1'b1);
    icresp(LX, 1'b1);
    expect_resp(32'hD2D2_0002, 1'b0);
    fetch(39'h1008);
    tick();

    // Kill cancels a registered hit response
    fetch(39'h100C);
    fetch_kill_i = 1'b1;
    @(negedge clk_i);
    chk("kill_cancels_hit", resp_valid_o, 0);
    tick();
    fetch_kill_i = 1'b0;
    tick();

    // Reset mid-flight clears the buffer; the refetch misses
    exp_req_q.push_back(39'h8000);
    fetch(39'h8000);
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    exp_req_q.push_back(39'h1004);
    fetch(39'h1004);
    expect_resp(32'hD1D1_0001, 1'b0);
    icresp(L1, 1'b0);
    tick(); tick();

    chk("final_hit_count", cnt_hit, 4);
    chk("final_miss_count", cnt_miss, 12);
    chk("resp_scoreboard_drained", exp_dat_q.size(), 0);
    chk("req_scoreboard_drained", exp_req_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
